sram_port_arbiter: RTL and testbench



---
 rtl/sram_port_arbiter.sv | 137 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port word SRAM between the instruction-fetch
// port (I) and the load/store port (D). D has priority, but I is guaranteed a grant
// after MAX_WAIT consecutive refusals. Reads return one cycle after the grant.
module sram_port_arbiter #(
    parameter int unsigned MEM_BYTES = 8192,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    // instruction-fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    // load/store port
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    // SRAM side
    output logic        HSEL,
    output logic        HWRITE,
    output logic [31:0] HADDR,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 32;

    logic [CNT_W-1:0]  wait_cnt;
    logic              win_i;
    logic              win_d;
    logic [ADDR_W-1:0] win_addr;
    logic              in_range;

    logic              i_rvalid_q;
    logic              d_rvalid_q;
    logic              i_err_q;
    logic              d_err_q;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;

    // Winner selection and SRAM drive; everything is forced idle while in reset
    always_comb begin
        win_i    = 1'b0;
        win_d    = 1'b0;
        win_addr = '0;
        in_range = 1'b0;
        HSEL     = 1'b0;
        HWRITE   = 1'b0;
        HADDR    = '0;
        HWDATA   = '0;

        if (!HRESET) begin
            if (i_req && d_req) begin
                if (wait_cnt == CNT_W'(MAX_WAIT)) begin
                    win_i = 1'b1;
                end else begin
                    win_d = 1'b1;
                end
            end else if (i_req) begin
                win_i = 1'b1;
            end else if (d_req) begin
                win_d = 1'b1;
            end
        end

        if (win_i) begin
            win_addr = i_addr;
        end else if (win_d) begin
            win_addr = d_addr;
        end

        if (win_i || win_d) begin
            in_range = (win_addr < ADDR_W'(MEM_BYTES));
            HADDR    = {win_addr[31:2], 2'b00};
        end

        // Out-of-range accesses are still granted but never reach the SRAM
        HSEL   = in_range;
        HWRITE = in_range && win_d && d_write;
        HWDATA = win_d ? d_wdata : 32'h0;
    end

    assign i_gnt = win_i;
    assign d_gnt = win_d;

    // Count consecutive refused fetch cycles, saturating at MAX_WAIT
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wait_cnt <= '0;
        end else if (!i_req || win_i) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Per-port response registers; rdata/err hold while no response is issued
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            i_rvalid_q <= win_i;
            d_rvalid_q <= win_d;
            if (win_i) begin
                i_err_q   <= !in_range;
                i_rdata_q <= in_range ? HRDATA : 32'h0;
            end
            if (win_d) begin
                d_err_q   <= !in_range;
                d_rdata_q <= (in_range && !d_write) ? HRDATA : 32'h0;
            end
        end
    end

    // A response falling in a cycle where reset has just been raised is dropped
    assign i_rvalid = i_rvalid_q && !HRESET;
    assign d_rvalid = d_rvalid_q && !HRESET;
    assign i_err    = i_err_q;
    assign d_err    = d_err_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural word SRAM behind it.
module tb_sram_port_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        HSEL;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;

    int total  = 0;
    int passed = 0;

    logic [31:0] mem [0:2047];

    sram_port_arbiter #(.MEM_BYTES(8192), .MAX_WAIT(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .HSEL(HSEL), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    // Word SRAM: combinational read, write on the rising edge; preset words reload in reset
    assign HRDATA = mem[HADDR[12:2]];
    always @(posedge HCLK) begin
        if (HRESET) begin
            mem[0]     <= 32'h0BADC0DE;
            mem[16]    <= 32'hDEADBEEF;
            mem[17]    <= 32'h11112222;
            mem[12'h7FF] <= 32'h5A5A5A5A;
        end else if (HSEL && HWRITE) begin
            mem[HADDR[12:2]] <= HWDATA;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESET  = 1'b1;
        i_req   = 1'b1;
        i_addr  = 32'h40;
        d_req   = 1'b1;
        d_addr  = 32'h44;
        d_write = 1'b1;
        d_wdata = 32'hAAAA5555;

        // reset with both requests high
        tick();
        #1;
        chk("rst_i_gnt", 32'(i_gnt), 32'h0);
        chk("rst_d_gnt", 32'(d_gnt), 32'h0);
        chk("rst_hsel", 32'(HSEL), 32'h0);
        chk("rst_hwrite", 32'(HWRITE), 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_i_rvalid", 32'(i_rvalid), 32'h0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_i_err", 32'(i_err), 32'h0);
        chk("rst_d_err", 32'(d_err), 32'h0);
        chk("rst_wait_cnt", 32'(dut.wait_cnt), 32'h0);
        tick();
        #1;
        chk("rst2_d_gnt", 32'(d_gnt), 32'h0);
        chk("rst2_hwrite", 32'(HWRITE), 32'h0);
        chk("rst2_hwdata", HWDATA, 32'h0);

        // release reset: D wins the first grant (a load of 0x44)
        HRESET  = 1'b0;
        d_write = 1'b0;
        #1;
        chk("rel_d_gnt", 32'(d_gnt), 32'h1);
        chk("rel_i_gnt", 32'(i_gnt), 32'h0);
        chk("rel_haddr", HADDR, 32'h44);
        chk("rel_hsel", 32'(HSEL), 32'h1);
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        #1;
        chk("rel_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("rel_d_rdata", d_rdata, 32'h11112222);
        chk("rel_i_rvalid", 32'(i_rvalid), 32'h0);
        chk("rel_wait_cnt", 32'(dut.wait_cnt), 32'h1);
        chk("idle_hsel", 32'(HSEL), 32'h0);
        chk("idle_haddr", HADDR, 32'h0);

        // single fetch from an unaligned address
        tick();
        chk("idle_d_rvalid", 32'(d_rvalid), 32'h0);
        chk("idle_d_rdata_hold", d_rdata, 32'h11112222);
        chk("idle_wait_cnt", 32'(dut.wait_cnt), 32'h0);
        i_req  = 1'b1;
        i_addr = 32'h43;
        #1;
        chk("f_i_gnt", 32'(i_gnt), 32'h1);
        chk("f_haddr", HADDR, 32'h40);
        chk("f_hsel", 32'(HSEL), 32'h1);
        chk("f_hwrite", 32'(HWRITE), 32'h0);
        tick();
        i_req = 1'b0;
        #1;
        chk("f_i_rvalid", 32'(i_rvalid), 32'h1);
        chk("f_i_rdata", i_rdata, 32'hDEADBEEF);
        chk("f_i_err", 32'(i_err), 32'h0);

        // store then load of the same word
        tick();
        chk("f_i_rvalid_off", 32'(i_rvalid), 32'h0);
        d_req   = 1'b1;
        d_write = 1'b1;
        d_addr  = 32'h100;
        d_wdata = 32'h12345678;
        #1;
        chk("st_d_gnt", 32'(d_gnt), 32'h1);
        chk("st_hwrite", 32'(HWRITE), 32'h1);
        chk("st_hwdata", HWDATA, 32'h12345678);
        chk("st_haddr", HADDR, 32'h100);
        tick();
        d_write = 1'b0;
        #1;
        chk("st_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("st_d_rdata", d_rdata, 32'h0);
        chk("ld_hwrite", 32'(HWRITE), 32'h0);
        chk("ld_hwdata", HWDATA, 32'h12345678);
        tick();
        d_req = 1'b0;
        #1;
        chk("ld_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("ld_d_rdata", d_rdata, 32'h12345678);
        chk("ld_hwdata_idle", HWDATA, 32'h0);
        tick();
        chk("ld_d_rvalid_off", 32'(d_rvalid), 32'h0);

        // contention for 12 cycles: pattern of 4 D grants then 1 I grant
        i_req   = 1'b1;
        i_addr  = 32'h40;
        d_req   = 1'b1;
        d_write = 1'b0;
        d_addr  = 32'h100;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk($sformatf("ct_i_gnt_%0d", c), 32'(i_gnt), (c % 5 == 4) ? 32'h1 : 32'h0);
            chk($sformatf("ct_d_gnt_%0d", c), 32'(d_gnt), (c % 5 == 4) ? 32'h0 : 32'h1);
            chk($sformatf("ct_wait_%0d", c), 32'(dut.wait_cnt), 32'(c % 5));
            chk($sformatf("ct_i_rvalid_%0d", c), 32'(i_rvalid),
                (c > 0 && (c - 1) % 5 == 4) ? 32'h1 : 32'h0);
            chk($sformatf("ct_d_rvalid_%0d", c), 32'(d_rvalid),
                (c > 0 && (c - 1) % 5 != 4) ? 32'h1 : 32'h0);
            tick();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        #1;
        chk("ct_i_rdata", i_rdata, 32'hDEADBEEF);
        chk("ct_d_rdata", d_rdata, 32'h12345678);

        // out-of-range store at exactly MEM_BYTES: granted but dropped
        tick();
        d_req   = 1'b1;
        d_write = 1'b1;
        d_addr  = 32'h2000;
        d_wdata = 32'hCAFEF00D;
        #1;
        chk("oor_d_gnt", 32'(d_gnt), 32'h1);
        chk("oor_hsel", 32'(HSEL), 32'h0);
        chk("oor_hwrite", 32'(HWRITE), 32'h0);
        tick();
        d_write = 1'b0;
        d_addr  = 32'h1FFC;
        #1;
        chk("oor_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("oor_d_err", 32'(d_err), 32'h1);
        chk("oor_d_rdata", d_rdata, 32'h0);
        chk("oor_mem0", mem[0], 32'h0BADC0DE);
        chk("top_hsel", 32'(HSEL), 32'h1);
        tick();
        d_req  = 1'b0;
        i_req  = 1'b1;
        i_addr = 32'hFFFFFFFC;
        #1;
        chk("top_d_err", 32'(d_err), 32'h0);
        chk("top_d_rdata", d_rdata, 32'h5A5A5A5A);
        chk("ioor_i_gnt", 32'(i_gnt), 32'h1);
        chk("ioor_hsel", 32'(HSEL), 32'h0);
        tick();
        i_req = 1'b0;
        #1;
        chk("ioor_i_rvalid", 32'(i_rvalid), 32'h1);
        chk("ioor_i_err", 32'(i_err), 32'h1);
        chk("ioor_i_rdata", i_rdata, 32'h0);

        // reset raised on the cycle after a fetch grant drops the response
        tick();
        i_req  = 1'b1;
        i_addr = 32'h40;
        #1;
        chk("mr_i_gnt", 32'(i_gnt), 32'h1);
        tick();
        HRESET = 1'b1;
        i_req  = 1'b0;
        #1;
        chk("mr_i_rvalid", 32'(i_rvalid), 32'h0);
        chk("mr_i_gnt_rst", 32'(i_gnt), 32'h0);
        tick();
        chk("mr_i_rvalid2", 32'(i_rvalid), 32'h0);
        chk("mr_wait_cnt", 32'(dut.wait_cnt), 32'h0);
        chk("mr_i_rdata", i_rdata, 32'h0);
        chk("mr_i_err", 32'(i_err), 32'h0);
        HRESET = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
